// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register-number width,
// FSM state encoding, control-bundle struct and the saturating counter helper.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_NUM_WIDTH    = 5;
  localparam int CTRL_STATE_WIDTH = 2;
  localparam int PERF_CNT_WIDTH   = 32;
  localparam int WD_WIDTH         = 16;

  typedef enum logic [CTRL_STATE_WIDTH-1:0] {
    CTRL_ST_RUN      = 2'd0,
    CTRL_ST_LD_STALL = 2'd1,
    CTRL_ST_MEM_WAIT = 2'd2,
    CTRL_ST_BR_FLUSH = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } hazard_ctrl_t;

  function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(
    input logic [PERF_CNT_WIDTH-1:0] val,
    input logic                      en
  );
    if (en && (val != {PERF_CNT_WIDTH{1'b1}})) begin
      return val + {{(PERF_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds
// the instruction in ID. Register 0 never matches.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_NUM_WIDTH-1:0] id_rs,
  input  logic [REG_NUM_WIDTH-1:0] id_rt,
  input  logic                     id_uses_rt,
  input  logic                     ex_is_load,
  input  logic [REG_NUM_WIDTH-1:0] ex_wr_num,
  output logic                     load_use
);

  assign load_use = ex_is_load
                  && (ex_wr_num != {REG_NUM_WIDTH{1'b0}})
                  && ((ex_wr_num == id_rs) || (id_uses_rt && (ex_wr_num == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush controls, sequencing FSM and
// memory-wait watchdog. Define PIPE_CTRL_PERF_EN to add StallCycles/FlushEvents.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REG_NUM_WIDTH-1:0]    IdRS,
  input  logic [REG_NUM_WIDTH-1:0]    IdRT,
  input  logic                        IdUsesRT,
  input  logic                        ExIsLoad,
  input  logic [REG_NUM_WIDTH-1:0]    ExWrNum,
  input  logic                        BrTaken,
  input  logic                        DmemReq,
  input  logic                        DmemAck,
  output logic                        PcStall,
  output logic                        IfIdStall,
  output logic                        IdExStall,
  output logic                        ExMemStall,
  output logic                        IfIdFlush,
  output logic                        IdExFlush,
  output logic                        ExMemFlush,
  output logic                        MemWbFlush,
  output logic [CTRL_STATE_WIDTH-1:0] CtrlState,
  output logic                        MemError
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0]   StallCycles,
  output logic [PERF_CNT_WIDTH-1:0]   FlushEvents
`endif
);

  ctrl_state_e         state_q, state_d;
  logic [WD_WIDTH-1:0] wd_q, wd_d;
  logic                mem_error_q, mem_error_d;
  logic                load_use_s;
  logic                mem_wait_s, freeze_s, release_s, br_s, ld_s;
  hazard_ctrl_t        ctrl_s;

  hazard_detect u_hazard_detect (
    .id_rs      (IdRS),
    .id_rt      (IdRT),
    .id_uses_rt (IdUsesRT),
    .ex_is_load (ExIsLoad),
    .ex_wr_num  (ExWrNum),
    .load_use   (load_use_s)
  );

  // A wait is frozen until the watchdog reaches MEM_TIMEOUT; any other cycle in MEM_WAIT is the release cycle.
  assign mem_wait_s = DmemReq && !DmemAck;
  assign freeze_s   = mem_wait_s
                   && !((state_q == CTRL_ST_MEM_WAIT) && (wd_q >= WD_WIDTH'(MEM_TIMEOUT)));
  assign release_s  = (state_q == CTRL_ST_MEM_WAIT) && !freeze_s;
  assign br_s       = BrTaken && (state_q != CTRL_ST_MEM_WAIT);
  assign ld_s       = load_use_s && (state_q == CTRL_ST_RUN);

  // State, watchdog and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CTRL_ST_RUN;
      wd_q        <= {WD_WIDTH{1'b0}};
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Next-state, watchdog and error update in priority order.
  always_comb begin
    state_d     = CTRL_ST_RUN;
    wd_d        = {WD_WIDTH{1'b0}};
    mem_error_d = mem_error_q;
    if (release_s) begin
      state_d     = CTRL_ST_RUN;
      mem_error_d = mem_error_q || mem_wait_s;
    end else if (freeze_s) begin
      state_d = CTRL_ST_MEM_WAIT;
      wd_d    = wd_q + {{(WD_WIDTH-1){1'b0}}, 1'b1};
    end else if (br_s) begin
      state_d = CTRL_ST_BR_FLUSH;
    end else if (ld_s) begin
      state_d = CTRL_ST_LD_STALL;
    end else begin
      state_d = CTRL_ST_RUN;
    end
  end

  // Mealy stall/flush controls, forced low while reset is asserted.
  always_comb begin
    ctrl_s = '0;
    if (!rst || release_s) begin
      ctrl_s = '0;
    end else if (freeze_s) begin
      ctrl_s.pc_stall     = 1'b1;
      ctrl_s.if_id_stall  = 1'b1;
      ctrl_s.id_ex_stall  = 1'b1;
      ctrl_s.ex_mem_stall = 1'b1;
      ctrl_s.mem_wb_flush = 1'b1;
    end else if (br_s) begin
      ctrl_s.if_id_flush  = 1'b1;
      ctrl_s.id_ex_flush  = 1'b1;
      ctrl_s.ex_mem_flush = 1'b1;
    end else if (ld_s) begin
      ctrl_s.pc_stall     = 1'b1;
      ctrl_s.if_id_stall  = 1'b1;
      ctrl_s.id_ex_flush  = 1'b1;
    end else begin
      ctrl_s = '0;
    end
  end

  assign PcStall    = ctrl_s.pc_stall;
  assign IfIdStall  = ctrl_s.if_id_stall;
  assign IdExStall  = ctrl_s.id_ex_stall;
  assign ExMemStall = ctrl_s.ex_mem_stall;
  assign IfIdFlush  = ctrl_s.if_id_flush;
  assign IdExFlush  = ctrl_s.id_ex_flush;
  assign ExMemFlush = ctrl_s.ex_mem_flush;
  assign MemWbFlush = ctrl_s.mem_wb_flush;
  assign CtrlState  = state_q;
  assign MemError   = mem_error_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_CNT_WIDTH-1:0] flush_events_q, flush_events_d;

  // Saturating performance counters.
  always_comb begin
    stall_cycles_d = sat_inc(stall_cycles_q, ctrl_s.pc_stall);
    flush_events_d = sat_inc(flush_events_q, ctrl_s.if_id_flush);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= {PERF_CNT_WIDTH{1'b0}};
      flush_events_q <= {PERF_CNT_WIDTH{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushEvents = flush_events_q;
`endif

endmodule
